// File: rtl/alarm_time_counter.sv
// rtl/alarm_time_counter.sv - BCD HH:MM:SS time counter with prescaler, 12/24-hour display, validated load and optional day of week (ALARM_TIME_DOW_EN)
module alarm_time_counter #(
   parameter int TICKS_PER_SEC = 1,
   parameter int PRESC_W       = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       hold,
   input  logic       mode_12h,
   input  logic       load_new_c,
   input  logic [3:0] new_current_time_ms_hr,
   input  logic [3:0] new_current_time_ls_hr,
   input  logic [3:0] new_current_time_ms_min,
   input  logic [3:0] new_current_time_ls_min,
   input  logic [3:0] new_current_time_ms_sec,
   input  logic [3:0] new_current_time_ls_sec,
   input  logic       new_pm,
   input  logic [2:0] new_dow,
   output logic [3:0] current_time_ms_hr,
   output logic [3:0] current_time_ls_hr,
   output logic [3:0] current_time_ms_min,
   output logic [3:0] current_time_ls_min,
   output logic [3:0] current_time_ms_sec,
   output logic [3:0] current_time_ls_sec,
   output logic       pm,
   output logic       min_tick,
   output logic       day_tick,
   output logic       load_err,
   output logic [2:0] dow
);

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);

   // Stored time is always 24-hour BCD; the 12-hour view is derived on the way out.
   logic [3:0]         hr_ms, hr_ls, min_ms, min_ls, sec_ms, sec_ls;
   logic [PRESC_W-1:0] presc;

   logic [3:0] nxt_hr_ms, nxt_hr_ls, nxt_min_ms, nxt_min_ls, nxt_sec_ms, nxt_sec_ls;
   logic       sec_wrap, day_wrap;
   logic       advance;

   logic [4:0] hr_bin, disp_hr;
   logic [4:0] new_hr_bin, load_hr;
   logic [3:0] load_hr_ms, load_hr_ls;
   logic       hr_ok, dow_ok, load_ok;

   // Hours 0..23 in binary to two BCD digits.
   function automatic logic [7:0] hr_to_bcd(input logic [4:0] h);
      if (h >= 5'd20)      return {4'd2, 4'(h - 5'd20)};
      else if (h >= 5'd10) return {4'd1, 4'(h - 5'd10)};
      else                 return {4'd0, 4'(h)};
   endfunction

   // A counted tick that completes a second, with no load competing for the edge.
   assign advance = !load_new_c && tick && !hold && (presc == PRESC_LAST);

   // Ripple the one-second increment through the BCD digits.
   always_comb begin
      nxt_hr_ms  = hr_ms;
      nxt_hr_ls  = hr_ls;
      nxt_min_ms = min_ms;
      nxt_min_ls = min_ls;
      nxt_sec_ms = sec_ms;
      nxt_sec_ls = sec_ls;
      sec_wrap   = 1'b0;
      day_wrap   = 1'b0;
      if (sec_ls != 4'd9) begin
         nxt_sec_ls = sec_ls + 4'd1;
      end else begin
         nxt_sec_ls = 4'd0;
         if (sec_ms != 4'd5) begin
            nxt_sec_ms = sec_ms + 4'd1;
         end else begin
            nxt_sec_ms = 4'd0;
            sec_wrap   = 1'b1;
            if (min_ls != 4'd9) begin
               nxt_min_ls = min_ls + 4'd1;
            end else begin
               nxt_min_ls = 4'd0;
               if (min_ms != 4'd5) begin
                  nxt_min_ms = min_ms + 4'd1;
               end else begin
                  nxt_min_ms = 4'd0;
                  if (hr_ms == 4'd2 && hr_ls == 4'd3) begin
                     nxt_hr_ms = 4'd0;
                     nxt_hr_ls = 4'd0;
                     day_wrap  = 1'b1;
                  end else if (hr_ls == 4'd9) begin
                     nxt_hr_ls = 4'd0;
                     nxt_hr_ms = hr_ms + 4'd1;
                  end else begin
                     nxt_hr_ls = hr_ls + 4'd1;
                  end
               end
            end
         end
      end
   end

   // Validate the load digits and convert a 12-hour load to the stored 24-hour form.
   always_comb begin
      new_hr_bin = 5'(new_current_time_ms_hr) * 5'd10 + 5'(new_current_time_ls_hr);
      if (mode_12h)
         hr_ok = (new_current_time_ms_hr == 4'd0 && new_current_time_ls_hr >= 4'd1 &&
                  new_current_time_ls_hr <= 4'd9) ||
                 (new_current_time_ms_hr == 4'd1 && new_current_time_ls_hr <= 4'd2);
      else
         hr_ok = (new_current_time_ms_hr <= 4'd1 && new_current_time_ls_hr <= 4'd9) ||
                 (new_current_time_ms_hr == 4'd2 && new_current_time_ls_hr <= 4'd3);
`ifdef ALARM_TIME_DOW_EN
      dow_ok = (new_dow <= 3'd6);
`else
      dow_ok = 1'b1;
`endif
      load_ok = hr_ok && dow_ok &&
                new_current_time_ms_min <= 4'd5 && new_current_time_ls_min <= 4'd9 &&
                new_current_time_ms_sec <= 4'd5 && new_current_time_ls_sec <= 4'd9;
      load_hr = new_hr_bin;
      if (mode_12h) begin
         if (new_hr_bin == 5'd12) load_hr = new_pm ? 5'd12 : 5'd0;
         else if (new_pm)         load_hr = new_hr_bin + 5'd12;
      end
      {load_hr_ms, load_hr_ls} = hr_to_bcd(load_hr);
   end

   // Time, prescaler and pulse registers: reset beats load, load beats advance.
   always_ff @(posedge clk) begin
      if (!reset) begin
         hr_ms    <= 4'd0;
         hr_ls    <= 4'd0;
         min_ms   <= 4'd0;
         min_ls   <= 4'd0;
         sec_ms   <= 4'd0;
         sec_ls   <= 4'd0;
         presc    <= '0;
         min_tick <= 1'b0;
         day_tick <= 1'b0;
         load_err <= 1'b0;
      end else begin
         min_tick <= 1'b0;
         day_tick <= 1'b0;
         load_err <= 1'b0;
         if (load_new_c) begin
            if (load_ok) begin
               hr_ms  <= load_hr_ms;
               hr_ls  <= load_hr_ls;
               min_ms <= new_current_time_ms_min;
               min_ls <= new_current_time_ls_min;
               sec_ms <= new_current_time_ms_sec;
               sec_ls <= new_current_time_ls_sec;
               presc  <= '0;
            end else begin
               load_err <= 1'b1;
            end
         end else if (tick && !hold) begin
            if (advance) begin
               presc    <= '0;
               hr_ms    <= nxt_hr_ms;
               hr_ls    <= nxt_hr_ls;
               min_ms   <= nxt_min_ms;
               min_ls   <= nxt_min_ls;
               sec_ms   <= nxt_sec_ms;
               sec_ls   <= nxt_sec_ls;
               min_tick <= sec_wrap;
               day_tick <= day_wrap;
            end else begin
               presc <= presc + PRESC_W'(1);
            end
         end
      end
   end

`ifdef ALARM_TIME_DOW_EN
   logic [2:0] dow_cnt;

   // Day of week follows the midnight wrap and is loaded alongside the time.
   always_ff @(posedge clk) begin
      if (!reset) begin
         dow_cnt <= 3'd0;
      end else if (load_new_c) begin
         if (load_ok) dow_cnt <= new_dow;
      end else if (advance && day_wrap) begin
         dow_cnt <= (dow_cnt == 3'd6) ? 3'd0 : dow_cnt + 3'd1;
      end
   end

   assign dow = dow_cnt;
`else
   logic unused_new_dow;
   assign unused_new_dow = ^new_dow;
   assign dow = 3'd0;
`endif

   // Display mapping: only the hour digits depend on mode_12h.
   always_comb begin
      hr_bin  = 5'(hr_ms) * 5'd10 + 5'(hr_ls);
      disp_hr = hr_bin;
      if (mode_12h) begin
         if (hr_bin == 5'd0)       disp_hr = 5'd12;
         else if (hr_bin > 5'd12)  disp_hr = hr_bin - 5'd12;
      end
   end

   assign {current_time_ms_hr, current_time_ls_hr} = hr_to_bcd(disp_hr);
   assign current_time_ms_min = min_ms;
   assign current_time_ls_min = min_ls;
   assign current_time_ms_sec = sec_ms;
   assign current_time_ls_sec = sec_ls;
   assign pm                  = (hr_bin >= 5'd12);

endmodule

// File: doc/alarm_time_counter.md
Name: alarm_time_counter

Overview:
- Parametrised successor to the alarm clock's HH:MM time counter.
- Adds BCD seconds, a prescaled tick input, a runtime 12/24-hour display mode, a hold/freeze input and load validation with an error pulse.
- Also adds minute and day carry pulses and an optional day-of-week counter.
- Sits between the tick generator and the alarm comparator/display mux. Time is kept internally in 24-hour BCD.

Parameters:
- TICKS_PER_SEC, 1, number of tick strobes per one-second advance (1..1024).
- PRESC_W, 10, width of the internal prescaler counter; must satisfy 2^PRESC_W >= TICKS_PER_SEC.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- tick  in  1  single-cycle timebase strobe
- hold  in  1  1 = freeze time; ticks are ignored and the prescaler keeps its value
- mode_12h  in  1  1 = 12-hour display and load format, 0 = 24-hour
- load_new_c  in  1  load request, sampled every cycle
- new_current_time_ms_hr / ls_hr / ms_min / ls_min / ms_sec / ls_sec  in  4 each  BCD load digits
- new_pm  in  1  PM flag for a load in 12-hour mode
- new_dow  in  3  load value for day of week (used only with DOW_EN)
- current_time_ms_hr / ls_hr / ms_min / ls_min / ms_sec / ls_sec  out  4 each  displayed BCD time
- pm  out  1  1 when internal hour >= 12, in either mode
- min_tick  out  1  one-cycle pulse on a seconds wrap 59->00
- day_tick  out  1  one-cycle pulse on 23:59:59 -> 00:00:00
- load_err  out  1  one-cycle pulse when a load is rejected
- dow  out  3  day of week, 0..6

Behaviour:
- Reset (reset==0 at a clk edge):
  - internal time 00:00:00, prescaler 0, dow 0
  - min_tick, day_tick and load_err all 0
  - outputs read 00:00:00 in 24-hour mode, or 12:00:00 with pm=0 in 12-hour mode
- Priority each edge: reset > load > advance.
- Advance:
  - The prescaler counts only when tick=1 and hold=0.
  - When the prescaler equals TICKS_PER_SEC-1 on a counted tick, it clears to 0 and the time advances 1 s on that same edge.
  - Otherwise the prescaler increments and the time is unchanged.
- Digit carries: ls_sec 9->0 carries to ms_sec; ms_sec 5->0 carries to ls_min; ls_min 9->0 to ms_min; ms_min 5->0 to the hour.
- Hours: 23->00. ls_hr 9->0 carries to ms_hr, except 23, which wraps the whole hour to 00.
- Carry pulses are registered on the same edge that updates the time, so each pulse is coincident with the new value for one cycle:
  - min_tick=1 when the seconds wrap 59->00.
  - day_tick=1 when the time wraps to 00:00:00; min_tick is also 1 that cycle.
- Load (load_new_c=1, reset=1):
  - Valid load, 24-hour mode: hour 00..23, ms_min<=5, ls_min<=9, ms_sec<=5, ls_sec<=9, all digits BCD.
  - Valid load, 12-hour mode: hour 01..12, minute and second rules as above.
  - 12-hour load converts to 24-hour: 12 AM->00, 12 PM->12, h PM->h+12 (h=1..11), h AM->h.
  - A valid load updates the time on the next edge, clears the prescaler and, with DOW_EN, loads dow from new_dow (new_dow>6 is invalid).
  - An invalid load leaves all state unchanged and pulses load_err=1 for one cycle.
  - A tick in the same cycle as any load is dropped, and no carry pulse is produced.
  - A load is accepted while hold=1.
- Display (combinational from the registers and mode_12h):
  - 24-hour mode shows the internal hour.
  - 12-hour mode maps 00->12, 13..23->01..11, and 01..12 unchanged.
  - The minute and second digits are identical in both modes.
  - Changing mode_12h never alters stored state.
- Reset mid-count discards the prescaler progress and any pending pulse.
- Outputs change only at clk edges, apart from the mode_12h display mapping.

Optional Feature:
- Macro: ALARM_TIME_DOW_EN.
- Defined: the dow register resets to 0, increments on every day_tick, wraps 6->0, and loads from new_dow on a valid load.
- Not defined: dow is tied to 0, new_dow is ignored, and new_dow never contributes to load_err.

Test Plan:
- TICKS_PER_SEC=1, 24-hour mode: load 09:59:59, one tick -> 10:00:00, min_tick=1 for one cycle, day_tick=0.
- Load 23:59:59, dow=6 (DOW_EN defined), one tick -> 00:00:00, min_tick=1, day_tick=1, dow=0, pm=0.
- 12-hour mode: load 12:00:00 with new_pm=0 -> 24-hour readback 00:00:00; load 11:59:59 PM, one tick -> display 12:00:00, pm=0, day_tick=1.
- Invalid loads: 24:00:00 in 24-hour mode, 00:30:00 in 12-hour mode, 12:60:00 -> each gives load_err=1 for one cycle and the previous time is held.
- TICKS_PER_SEC=4: load 00:00:58, six ticks with hold=1 for ticks 2-3 -> 00:00:59 after the fourth counted tick; a load issued in the same cycle as a tick drops that tick.
- reset=0 asserted mid-count at 12:34:56 -> next edge gives 00:00:00 with all pulses 0; after release, TICKS_PER_SEC ticks are needed to reach 00:00:01.
